jtag_bus_bridge: RTL
====================

# jtag_bus_bridge

Command consumer sitting directly downstream of the JTAG TAP's user-data register. On each completed user DR update it decodes the TAP's `userOp` and `userData_out`, and runs one single-beat transaction on a simple req/ack register bus: address load, write, read, auto-increment, or status. It returns read data and status to the TAP through `userData_in` for the next Capture-DR. The block runs entirely in the TCK domain.

## Interface
- `USEROP_LEN`, 8, width of the opcode from the TAP
- `USERDATA_LEN`, 32, width of data to/from the TAP and the bus data width
- `ADDR_W`, 16, bus address width (≤ 16)
- `TIMEOUT`, 255, max cycles `bus_req` is held without `bus_ack` (≥ 1)

Ports:
- `tck`  in  1  clock; all logic on rising edge
- `trst`  in  1  reset; synchronous, active-low
- `userOp`  in  USEROP_LEN  opcode from TAP
- `userData_out`  in  USERDATA_LEN  operand from TAP
- `userOp_ready`  in  1  one-cycle pulse; `userOp`/`userData_out` valid this cycle
- `userData_in`  out  USERDATA_LEN  response word to TAP, registered
- `bus_req`  out  1  transaction request, registered
- `bus_we`  out  1  1 = write, 0 = read; valid while `bus_req`
- `bus_addr`  out  ADDR_W  current address pointer
- `bus_wdata`  out  USERDATA_LEN  write data; valid while `bus_req`
- `bus_ack`  in  1  completion; sampled only while `bus_req`=1
- `bus_rdata`  in  USERDATA_LEN  read data; valid with `bus_ack` on reads

## Operation
- Opcodes (low 3 bits decoded; upper bits must be 0, else bad-op):
  - 0x00 NOP
  - 0x01 SET_ADDR
  - 0x02 WRITE
  - 0x03 READ
  - 0x04 WRITE_INC
  - 0x05 READ_INC
  - 0x06 STATUS
  - anything else: bad-op
- State machine IDLE → BUS → IDLE.
  - IDLE + accepted WRITE/READ/_INC: latch `bus_we`, `bus_wdata`=`userData_out`; go to BUS.
  - BUS: `bus_req`=1 until `bus_ack` or timeout, then return to IDLE.
- SET_ADDR: `bus_addr` ← `userData_out[ADDR_W-1:0]`. No bus cycle.
- Read ack: `userData_in` ← `bus_rdata`. Write ack: `userData_in` unchanged.
- _INC ops: `bus_addr` ← `bus_addr`+1, mod 2^ADDR_W, on the ack cycle only. 0xFFFF wraps to 0x0000.
- Timeout:
  - Counter clears on entry to BUS and increments each BUS cycle without ack.
  - At count == TIMEOUT: drop `bus_req`, set sticky `err_to`, no address increment.
  - On a read timeout, `userData_in` ← 0xDEAD_BEEF.
- STATUS is accepted in any state.
  - `userData_in` ← {bus_addr zero-extended to 16 bits, 12'b0, bad_op, err_to, overrun, busy}.
  - `busy` is 1 in BUS.
  - Same edge: clears the sticky flags `bad_op`, `err_to`, `overrun`. A flag set by the same-cycle event is not cleared.
- Busy handling: NOP/SET_ADDR/bus opcode with `userOp_ready` while in BUS is dropped and sets sticky `overrun`. This includes the ack cycle itself.
- Bad-op sets sticky `bad_op`; no other effect.
- `userOp_ready` is ignored while `trst`=0.

## Timing
- Reset (`trst`=0 at an edge) clears: `userData_in`, `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, all flags, and the timeout counter. State returns to IDLE.
- Reset mid-BUS: `bus_req` low after that edge; no increment; no data update.
- `userOp_ready` at edge N (IDLE, bus op) → `bus_req`, `bus_we`, `bus_wdata` valid after edge N.
- `bus_ack` sampled high at edge M:
  - `bus_req` low after M.
  - `userData_in` (reads) and `bus_addr` (_INC) updated after M.
  - Next op accepted at edge M+1.
- Minimum bus op = 2 edges (ack in the first `bus_req` cycle).
- Timeout: `bus_req` high for exactly TIMEOUT cycles, then low. `err_to` is set on the same edge `bus_req` drops.
- SET_ADDR/STATUS: result visible one edge after `userOp_ready`.
- `bus_addr`, `bus_we`, `bus_wdata` are stable throughout `bus_req`=1.

## Test plan
- Reset then STATUS → `userData_in`=0x0000_0000; all bus outputs 0.
- SET_ADDR 0x0010, then WRITE 0xA5A5_5A5A, ack after 3 cycles → bus write to addr 0x0010 with `bus_req` high 3 cycles; `bus_addr` stays 0x0010.
- SET_ADDR 0xFFFF, READ_INC ×2, rdata 0x1111_1111 then 0x2222_2222 → reads at 0xFFFF, 0x0000; `userData_in`=0x2222_2222; `bus_addr`=0x0001.
- READ with no ack, TIMEOUT=255 → `bus_req` high 255 cycles; `userData_in`=0xDEAD_BEEF; STATUS returns bit2=1; a second STATUS returns bit2=0.
- WRITE held off by ack; issue READ and STATUS mid-BUS → READ dropped; STATUS shows busy=1, overrun=1.
- Opcode 0x07 and 0x83 → no bus activity; STATUS bit3=1. Assert `trst`=0 mid-BUS → `bus_req`=0 next edge; `bus_addr`=0.

Source files
------------

// File: rtl/jtag_bus_bridge.sv
// Executes one single-beat register-bus transaction per completed JTAG user DR update.
// Returns read data or a status word to the TAP; everything runs on TCK.
module jtag_bus_bridge #(
  parameter int USEROP_LEN   = 8,
  parameter int USERDATA_LEN = 32,
  parameter int ADDR_W       = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                    tck,
  input  logic                    trst,
  input  logic [USEROP_LEN-1:0]   userOp,
  input  logic [USERDATA_LEN-1:0] userData_out,
  input  logic                    userOp_ready,
  output logic [USERDATA_LEN-1:0] userData_in,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [USERDATA_LEN-1:0] bus_wdata,
  input  logic                    bus_ack,
  input  logic [USERDATA_LEN-1:0] bus_rdata,
  output logic                    o_dbg_state
);

  // Bus handshake: bus_req rises one edge after an accepted bus opcode and holds
  // bus_we/bus_addr/bus_wdata stable; the first edge that samples bus_ack high
  // completes the beat and drops bus_req. No ack within TIMEOUT cycles aborts it.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SET_ADDR  = 3'd1;
  localparam logic [2:0] OP_WRITE     = 3'd2;
  localparam logic [2:0] OP_READ      = 3'd3;
  localparam logic [2:0] OP_WRITE_INC = 3'd4;
  localparam logic [2:0] OP_READ_INC  = 3'd5;
  localparam logic [2:0] OP_STATUS    = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

  state_t                  r_state;
  logic [USERDATA_LEN-1:0] r_data_in;
  logic                    r_req;
  logic                    r_we;
  logic                    r_inc;
  logic [ADDR_W-1:0]       r_addr;
  logic [USERDATA_LEN-1:0] r_wdata;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_bad_op;
  logic                    r_err_to;
  logic                    r_overrun;

  logic [2:0]       w_op;
  logic             w_hi_zero;
  logic             w_is_nop;
  logic             w_is_setaddr;
  logic             w_is_busop;
  logic             w_is_status;
  logic             w_is_bad;
  logic             w_in_bus;
  logic             w_ack;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_set_overrun;
  logic [31:0]      w_status;

  assign w_op         = userOp[2:0];
  assign w_hi_zero    = (userOp[USEROP_LEN-1:3] == '0);
  assign w_is_nop     = userOp_ready && w_hi_zero && (w_op == OP_NOP);
  assign w_is_setaddr = userOp_ready && w_hi_zero && (w_op == OP_SET_ADDR);
  assign w_is_busop   = userOp_ready && w_hi_zero &&
                        (w_op >= OP_WRITE) && (w_op <= OP_READ_INC);
  assign w_is_status  = userOp_ready && w_hi_zero && (w_op == OP_STATUS);
  assign w_is_bad     = userOp_ready && (!w_hi_zero || (w_op == 3'd7));

  assign w_in_bus      = (r_state == S_BUS);
  assign w_ack         = w_in_bus && bus_ack;
  assign w_cnt_next    = r_cnt + 1'b1;
  assign w_timeout     = w_in_bus && !bus_ack && (w_cnt_next == CNT_W'(TIMEOUT));
  assign w_set_overrun = w_in_bus && (w_is_nop || w_is_setaddr || w_is_busop);

  assign w_status = {16'(r_addr), 12'b0, r_bad_op, r_err_to, r_overrun, w_in_bus};

  always_ff @(posedge tck) begin
    if (!trst) begin
      r_state   <= S_IDLE;
      r_data_in <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_inc     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_bad_op  <= 1'b0;
      r_err_to  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_setaddr) begin
            r_addr <= userData_out[ADDR_W-1:0];
          end
          if (w_is_busop) begin
            r_req   <= 1'b1;
            r_we    <= (w_op == OP_WRITE) || (w_op == OP_WRITE_INC);
            r_inc   <= (w_op == OP_WRITE_INC) || (w_op == OP_READ_INC);
            r_wdata <= userData_out;
            r_cnt   <= '0;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            if (!r_we) r_data_in <= bus_rdata;
            if (r_inc) r_addr <= r_addr + 1'b1;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            if (!r_we) r_data_in <= USERDATA_LEN'(32'hDEAD_BEEF);
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // STATUS takes priority for the response word; same-cycle flag sets survive its clear.
      if (w_is_status) r_data_in <= USERDATA_LEN'(w_status);
      r_bad_op  <= (r_bad_op  && !w_is_status) || w_is_bad;
      r_err_to  <= (r_err_to  && !w_is_status) || w_timeout;
      r_overrun <= (r_overrun && !w_is_status) || w_set_overrun;
    end
  end

  assign userData_in = r_data_in;
  assign bus_req     = r_req;
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_wdata   = r_wdata;
  assign o_dbg_state = r_state;

endmodule
